// File: rtl/dcache_miss_ctrl_if.sv
// Data-cache miss sequencer bus: pipeline side and main-memory side.
// slave = sequencer, master = pipeline/cache/memory environment.
interface dcache_miss_ctrl_if #(
  parameter int IDX_W = 2
);
  logic             mem_read;
  logic             mem_write;
  logic [31:0]      addr;
  logic [31:0]      wdata;
  logic             tag_hit;
  logic             pipe_go;
  logic             stall;
  logic             mem_req;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             mem_ack;
  logic [31:0]      mem_rdata;
  logic             fill_we;
  logic [IDX_W-1:0] fill_idx;
  logic [31:0]      fill_data;
  logic             tag_we;

  modport slave (
    input  mem_read, mem_write, addr, wdata, tag_hit,
    input  mem_ack, mem_rdata,
    output pipe_go, stall,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output fill_we, fill_idx, fill_data, tag_we
  );

  modport master (
    output mem_read, mem_write, addr, wdata, tag_hit,
    output mem_ack, mem_rdata,
    input  pipe_go, stall,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  fill_we, fill_idx, fill_data, tag_we
  );
endinterface

// File: rtl/dcache_miss_ctrl.sv
// MEM-stage data-cache sequencer: load-miss line refill and
// write-through store, freezing the pipeline while memory works.
module dcache_miss_ctrl #(
  parameter int WORDS_PER_LINE = 4,
  parameter int IDX_W          = 2
) (
  input logic                clk,
  input logic                rst,
  dcache_miss_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    WRITE   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS_PER_LINE - 1);
  localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

  state_t           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [IDX_W-1:0] beat_q, beat_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      maddr_q, maddr_d;
  logic [IDX_W-1:0] beat_nx;
  logic             unused_addr_lsbs;

  assign beat_nx          = beat_q + ONE;
  assign unused_addr_lsbs = &{1'b0, addr_q[IDX_W+1:0]};

  // State and registered memory-port outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      beat_q  <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      maddr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      beat_q  <= beat_d;
      req_q   <= req_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
    end
  end

  // Next state, pipeline control and cache-fill strobes
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    beat_d      = beat_q;
    req_d       = req_q;
    we_d        = we_q;
    maddr_d     = maddr_q;
    bus.pipe_go = 1'b0;
    bus.stall   = 1'b0;
    bus.fill_we = 1'b0;
    bus.tag_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_write) begin
          bus.stall = 1'b1;
          state_d   = WRITE;
          addr_d    = bus.addr;
          wdata_d   = bus.wdata;
          req_d     = 1'b1;
          we_d      = 1'b1;
          maddr_d   = {bus.addr[31:2], 2'b00};
        end else if (bus.mem_read && !bus.tag_hit) begin
          bus.stall = 1'b1;
          state_d   = FILL;
          addr_d    = bus.addr;
          beat_d    = '0;
          req_d     = 1'b1;
          we_d      = 1'b0;
          maddr_d   = {bus.addr[31:2+IDX_W], {IDX_W{1'b0}}, 2'b00};
        end else begin
          bus.pipe_go = 1'b1;
        end
      end
      FILL: begin
        bus.stall = 1'b1;
        if (bus.mem_ack) begin
          bus.fill_we = 1'b1;
          beat_d      = beat_nx;
          maddr_d     = maddr_q + 32'd4;
          if (beat_q == LAST) begin
            bus.tag_we = 1'b1;
            req_d      = 1'b0;
            state_d    = RELEASE;
          end
        end
      end
      WRITE: begin
        bus.stall = 1'b1;
        if (bus.mem_ack) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        bus.pipe_go = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      bus.pipe_go = 1'b0;
      bus.stall   = 1'b0;
      bus.fill_we = 1'b0;
      bus.tag_we  = 1'b0;
    end
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.fill_idx  = beat_q;
  assign bus.fill_data = bus.mem_rdata;

endmodule
